layer_serializer: RTL and testbench
===================================

// Module: layer_serializer
// PURPOSE
//  Inter-layer sequencer between two fully-connected layers. Captures the NN parallel
//  neuron outputs of layer k when all their valid bits are high and replays them one
//  word per cycle as the serial x_in/x_valid stream that feeds layer k+1.
//  It also flags dropped frames and partial-valid faults.
// PARAMETERS
//  NN         30  neurons in source layer = words per frame
//  dataWidth  16  width of one neuron output word
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active-low (0 = reset)
//  in_valid   in   NN            per-neuron outvalid bits from source layer
//  in_data    in   NN*dataWidth  neuron n at [n*dataWidth +: dataWidth]
//  out_ready  in   1             sink accepts word this cycle (tie 1 for neuron layers)
//  x_valid    out  1             serial word valid
//  x_data     out  dataWidth     serial word
//  x_last     out  1             high with the word from neuron NN-1
//  busy       out  1             frame buffered / shifting
//  frame_done out  1             1-cycle pulse after last word accepted
//  ovf        out  1             sticky: frame arrived while busy and was dropped
//  part_err   out  1             sticky: in_valid nonzero but not all ones
//  clr_flags  in   1             clears ovf and part_err (lower priority than set)
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE, idx=0, buffer=0; x_valid, x_data, x_last, busy,
//   frame_done, ovf, part_err all 0. Reset mid-frame discards the frame silently.
//  cap = &in_valid. State regs: IDLE, SHIFT. idx width = max(1,$clog2(NN)).
//  IDLE: cap -> latch in_data into buffer, idx=0, go SHIFT. No cap -> stay.
//  SHIFT: x_valid=1, x_data=buffer[idx*dataWidth +: dataWidth], x_last=(idx==NN-1),
//   busy=1. out_ready=0 -> hold x_data/idx (stall, word must not change).
//   out_ready=1 and idx<NN-1 -> idx++.
//   out_ready=1 and idx==NN-1 -> frame_done=1 next cycle; if cap same cycle, latch
//   new frame, idx=0, stay SHIFT (back-to-back, no bubble); else go IDLE.
//  Latency: cap at edge T -> word 0 on x_data during cycle T+1; with out_ready held
//   high, word n during T+1+n; frame_done high during T+1+NN.
//  cap in SHIFT other than the final-accept cycle -> new frame dropped, ovf<=1;
//   current frame continues untouched.
//  part_err<=1 when in_valid!=0 and !cap (any state). Set wins over clr_flags same cycle.
//  Outputs are registered; x_data is 0 whenever x_valid==0.
//  NN==1: single-word frames; x_last always 1 while x_valid.
// TESTING
//  T1 reset: rst=0 two cycles with in_valid all ones -> all outputs 0, no capture.
//  T2 single frame NN=4, words 0x0011,0x0022,0x0033,0x0044, out_ready=1 -> x_data
//     0x0011..0x0044 on 4 consecutive cycles, x_last on 0x0044, frame_done next cycle.
//  T3 stall: out_ready=0 for 3 cycles while 0x0022 shown -> 0x0022 held, idx frozen,
//     stream resumes with 0x0033 when out_ready=1.
//  T4 back-to-back: second frame cap on the 0x0044 accept cycle -> its word 0 follows
//     immediately, x_valid never drops, ovf stays 0.
//  T5 overflow/partial: cap while showing word 1 -> ovf=1, frame 1 intact; in_valid=4'b0101
//     -> part_err=1; clr_flags -> both 0.
//  T6 rst=0 during word 2 -> next cycle x_valid=0, busy=0; new cap afterwards starts at word 0.

Source files
------------

// File: rtl/layer_serializer.sv
`default_nettype none
// ============================================================================
// Module   : layer_serializer
// Captures a full-valid parallel layer output and replays it one word/cycle.
// Revision : 1.0
// ============================================================================
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    input  logic                    out_ready,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_data,
    output logic                    x_last,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    ovf,
    output logic                    part_err,
    input  logic                    clr_flags
);

    localparam int             IW       = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_n;
    logic [NN*dataWidth-1:0] buffer;
    logic [NN*dataWidth-1:0] buffer_n;

    logic                    cap;
    logic                    final_accept;
    logic                    drop;
    logic                    partial;
    logic                    x_valid_n;
    logic [dataWidth-1:0]    x_data_n;
    logic                    x_last_n;
    logic                    ovf_n;
    logic                    part_err_n;

    always_comb begin
        cap          = &in_valid;
        final_accept = (state == SHIFT) && out_ready && (idx == LAST_IDX);
        drop         = (state == SHIFT) && cap && !final_accept;
        partial      = (in_valid != '0) && !cap;

        state_n  = state;
        idx_n    = idx;
        buffer_n = buffer;

        case (state)
            IDLE: begin
                if (cap) begin
                    buffer_n = in_data;
                    idx_n    = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (idx != LAST_IDX) begin
                        idx_n = idx + 1'b1;
                    end else if (cap) begin
                        // back-to-back frame: reload on the final accept, no bubble
                        buffer_n = in_data;
                        idx_n    = '0;
                    end else begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase

        // outputs are registered, so derive them from the next-cycle view
        x_valid_n  = (state_n == SHIFT);
        x_data_n   = x_valid_n ? buffer_n[idx_n*dataWidth +: dataWidth] : '0;
        x_last_n   = x_valid_n && (idx_n == LAST_IDX);

        ovf_n      = drop    ? 1'b1 : (clr_flags ? 1'b0 : ovf);
        part_err_n = partial ? 1'b1 : (clr_flags ? 1'b0 : part_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            buffer     <= '0;
            x_valid    <= 1'b0;
            x_data     <= '0;
            x_last     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
            part_err   <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            buffer     <= buffer_n;
            x_valid    <= x_valid_n;
            x_data     <= x_data_n;
            x_last     <= x_last_n;
            busy       <= x_valid_n;
            frame_done <= final_accept;
            ovf        <= ovf_n;
            part_err   <= part_err_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_serializer
// Directed plus randomized bench for layer_serializer against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_layer_serializer;

    localparam int NN = 4;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NN-1:0]    in_valid;
    logic [NN*DW-1:0] in_data;
    logic             out_ready;
    logic             clr_flags;
    logic             x_valid;
    logic [DW-1:0]    x_data;
    logic             x_last;
    logic             busy;
    logic             frame_done;
    logic             ovf;
    logic             part_err;

    int checks   = 0;
    int failures = 0;

    // frame-level model: the frame being replayed and the position within it
    bit              m_active;
    logic [DW-1:0]   m_frame [NN];
    int              m_pos;
    bit              m_done;
    bit              m_ovf;
    bit              m_perr;

    always #5 clk = ~clk;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .x_valid    (x_valid),
        .x_data     (x_data),
        .x_last     (x_last),
        .busy       (busy),
        .frame_done (frame_done),
        .ovf        (ovf),
        .part_err   (part_err),
        .clr_flags  (clr_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        in_data = {w3, w2, w1, w0};
    endtask

    task automatic model_edge();
        bit full;
        bit fin;
        full = (in_valid == {NN{1'b1}});
        if (!rst) begin
            m_active = 0; m_pos = 0; m_done = 0; m_ovf = 0; m_perr = 0;
            return;
        end
        fin    = m_active && out_ready && (m_pos == NN - 1);
        m_done = fin;
        if (in_valid != '0 && !full) m_perr = 1;
        else if (clr_flags)          m_perr = 0;
        if (m_active && full && !fin) m_ovf = 1;
        else if (clr_flags)           m_ovf = 0;
        if (m_active) begin
            if (out_ready) begin
                if (m_pos < NN - 1) m_pos++;
                else if (full) begin
                    for (int i = 0; i < NN; i++) m_frame[i] = in_data[i*DW +: DW];
                    m_pos = 0;
                end else m_active = 0;
            end
        end else if (full) begin
            for (int i = 0; i < NN; i++) m_frame[i] = in_data[i*DW +: DW];
            m_pos    = 0;
            m_active = 1;
        end
    endtask

    task automatic check_all();
        check("x_valid",    32'(x_valid),    32'(m_active));
        check("x_data",     32'(x_data),     m_active ? 32'(m_frame[m_pos]) : 32'd0);
        check("x_last",     32'(x_last),     32'(m_active && m_pos == NN - 1));
        check("busy",       32'(busy),       32'(m_active));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("ovf",        32'(ovf),        32'(m_ovf));
        check("part_err",   32'(part_err),   32'(m_perr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        m_active = 0; m_pos = 0; m_done = 0; m_ovf = 0; m_perr = 0;
        for (int i = 0; i < NN; i++) m_frame[i] = '0;
        rst = 1'b0; in_valid = '1; out_ready = 1'b1; clr_flags = 1'b0;
        load_words(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        #1;

        // T1: reset holds everything at zero even with a full-valid frame
        step(); step();
        check("t1_x_valid", 32'(x_valid), 32'd0);
        check("t1_busy",    32'(busy),    32'd0);
        rst = 1'b1; in_valid = '0;
        step();

        // T2: single frame
        load_words(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        in_valid = '1; step(); in_valid = '0;
        check("t2_w0", 32'(x_data), 32'h0011);
        step(); check("t2_w1", 32'(x_data), 32'h0022);
        step(); check("t2_w2", 32'(x_data), 32'h0033);
        step(); check("t2_w3", 32'(x_data), 32'h0044);
        check("t2_last", 32'(x_last), 32'd1);
        step(); check("t2_done", 32'(frame_done), 32'd1);
        check("t2_idle", 32'(x_valid), 32'd0);

        // T3: stall while word 1 is shown
        in_valid = '1; step(); in_valid = '0;
        step(); check("t3_w1", 32'(x_data), 32'h0022);
        out_ready = 1'b0;
        step(); step(); step();
        check("t3_hold", 32'(x_data), 32'h0022);
        out_ready = 1'b1;
        step(); check("t3_resume", 32'(x_data), 32'h0033);
        step(); step();

        // T4: back-to-back frame captured on the final accept
        in_valid = '1; step(); in_valid = '0;
        step(); step(); step();
        check("t4_w3", 32'(x_data), 32'h0044);
        load_words(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        in_valid = '1; step(); in_valid = '0;
        check("t4_b0",    32'(x_data),     32'h0101);
        check("t4_valid", 32'(x_valid),    32'd1);
        check("t4_done",  32'(frame_done), 32'd1);
        check("t4_ovf",   32'(ovf),        32'd0);
        step(); step(); step(); step();

        // T5: overflow and partial-valid, then clear
        load_words(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        in_valid = '1; step(); in_valid = '0;
        step();
        load_words(16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C);
        in_valid = '1; step();
        check("t5_ovf",    32'(ovf),    32'd1);
        check("t5_intact", 32'(x_data), 32'h0033);
        in_valid = 4'b0101; step();
        check("t5_perr", 32'(part_err), 32'd1);
        in_valid = '0; step(); step();
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        check("t5_clr_ovf",  32'(ovf),      32'd0);
        check("t5_clr_perr", 32'(part_err), 32'd0);

        // T6: reset mid-frame, then a fresh capture restarts at word 0
        load_words(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        in_valid = '1; step(); in_valid = '0;
        step(); step();
        check("t6_w2", 32'(x_data), 32'h0033);
        rst = 1'b0; step(); rst = 1'b1;
        check("t6_valid", 32'(x_valid), 32'd0);
        check("t6_busy",  32'(busy),    32'd0);
        load_words(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        in_valid = '1; step(); in_valid = '0;
        check("t6_w0", 32'(x_data), 32'h1111);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 25)      in_valid = '1;
            else if (r < 32) in_valid = NN'($urandom);
            else             in_valid = '0;
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
